player_ctrl: RTL and testbench
==============================

Name: player_ctrl

Overview:
Parametrised successor to the player ship controller. Tracks ship position, lives and hit/dead/resume flow. Adds a move-rate divider, edge-triggered shooting with cooldown, bounded lives up to a maximum, and a blinking visibility output while the ship is in the hit state. Sits between the button inputs and the bullet spawner, collision logic and display pipeline.

Parameters:
pos_width_p, 10, width of all position buses
lives_width_p, 3, width of the lives counter
max_lives_p, 5, upper bound on spare lives
start_lives_p, 2, spare lives at reset and on a new game
ship_width_p, 40, ship width in pixels
left_border_p, 9, minimum pos_left_o
right_border_p, 630, maximum pos_right_o
start_left_p, 249, pos_left_o at reset and on resume
step_p, 10, pixels per movement step
move_div_p, 4, cycles per movement step while moving (>=1)
cooldown_p, 8, minimum cycles between shots (>=1)
flash_div_p, 16, cycles per visible_o toggle in the HIT state (>=1)

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
move_left_i  in  1  left button
move_right_i  in  1  right button
shoot_i  in  1  shoot / resume button (level)
hit_i  in  1  ship hit by an enemy this cycle
add_life_i  in  1  award one life (one-cycle pulse)
alive_o  out  1  high in every state except DEAD
shot_laser_o  out  1  one-cycle pulse that spawns a bullet
resume_o  out  1  one-cycle pulse when leaving HIT or DEAD
pos_left_o  out  pos_width_p  ship left edge
pos_right_o  out  pos_width_p  pos_left_o + ship_width_p
gun_pos_o  out  pos_width_p  pos_left_o + ship_width_p/2
lives_o  out  lives_width_p  spare lives
visible_o  out  1  ship drawn this cycle
state_o  out  3  encoded state, for debug

Behaviour:
- Reset (async, while reset_ni=0) sets these values: state IDLE; pos_left_o=start_left_p; lives_o=start_lives_p; shot_laser_o=0; resume_o=0; visible_o=1; move counter, cooldown counter and shoot-edge register all 0.
- State encoding: IDLE=0, LEFT=1, RIGHT=2, HIT=3, DEAD=4. Codes 5-7 are illegal and return to IDLE on the next edge.
- Definitions: dirL = move_left_i & ~move_right_i; dirR = ~move_left_i & move_right_i. atL = pos_left_o <= left_border_p. atR = pos_right_o >= right_border_p. shoot_edge = shoot_i & ~shoot_q, where shoot_q is shoot_i delayed one cycle.
- Priority in the alive states (IDLE, LEFT, RIGHT):
  - hit_i wins over every other input. If lives_o>0, lives_o decrements and the next state is HIT. If lives_o==0, the next state is DEAD.
  - On a hit cycle there is no step, no shot, and add_life_i is ignored.
- Movement when hit_i=0:
  - The next state is LEFT if dirL & ~atL, RIGHT if dirR & ~atR, and IDLE otherwise. LEFT and RIGHT switch directly to each other.
  - The move counter clears on any state change and in IDLE.
  - In LEFT or RIGHT, with the state unchanged, the counter counts 0..move_div_p-1. At move_div_p-1 it wraps and one step is applied on that edge.
  - Left step: pos_left = max(pos_left - step_p, left_border_p). Right step: pos_left = min(pos_left + step_p, right_border_p - ship_width_p). Both clamp with no underflow or wrap.
  - The entry cycle never steps. First step occurs move_div_p cycles after entry.
- Shooting, alive states only:
  - shot_laser_o=1 on the cycle after a shoot_edge when cooldown==0 and hit_i=0.
  - Firing loads cooldown with cooldown_p. Cooldown decrements to 0 every cycle.
  - Holding shoot_i fires once. A shoot_edge during cooldown is dropped, not queued.
- HIT state:
  - Position is frozen. hit_i and add_life_i are ignored.
  - visible_o is 0 on entry and toggles every flash_div_p cycles.
  - On shoot_edge: resume_o pulses; pos_left resets to start_left_p; cooldown loads cooldown_p; no shot fires. The next state is LEFT if dirL, RIGHT if dirR, otherwise IDLE. Lives are unchanged.
- DEAD state:
  - alive_o=0 and visible_o=0. hit_i and add_life_i are ignored.
  - On shoot_edge: same as resume from HIT, and lives_o also reloads start_lives_p.
- add_life_i: increments lives_o in alive states if lives_o < max_lives_p; saturates at max_lives_p.
- visible_o=1 in all alive states.
- alive_o is combinational from the state. All other outputs are registered.
- pos_right_o and gun_pos_o are combinational from pos_left_o and never wrap for legal parameters.
- Parameter legality is checked by elaboration-time assertions:
  - start_left_p lies within [left_border_p, right_border_p - ship_width_p].
  - start_lives_p <= max_lives_p < 2^lives_width_p.

Test Plan:
- Reset with defaults -> pos_left_o=249, pos_right_o=289, gun_pos_o=269, lives_o=2, state_o=0, visible_o=1.
- Hold move_left_i for 200 cycles -> state_o=1; pos_left_o falls by 10 every 4 cycles (first step at cycle 4); clamps at 9; state returns to 0 and stays at 9.
- Hold shoot_i 20 cycles, then pulse 3 cycles after the first shot, then pulse 10 cycles after it -> exactly two shot_laser_o pulses (first and third press); the second press is dropped.
- hit_i with lives_o=2 -> lives_o=1, state_o=3; visible_o toggles every 16 cycles. A further hit_i is ignored. shoot edge with move_right_i held -> resume_o pulse, pos_left_o=249, state_o=2, no shot.
- hit_i at lives_o=0 -> state_o=4, alive_o=0, visible_o=0. shoot edge -> lives_o=2, state_o=0, resume_o pulse.
- Six add_life_i pulses from lives_o=2 -> saturates at 5. add_life_i and hit_i in the same cycle with lives_o=3 -> lives_o=2, state HIT.
- Assert reset_ni mid-move, asynchronously away from the clock edge -> outputs take reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/player_ctrl.sv
// Player ship controller: position, lives, shooting and hit/dead/resume flow.
// All outputs registered except alive_o/pos_right_o/gun_pos_o; no backpressure, decisions land on the next edge.
module player_ctrl #(
   parameter int pos_width_p   = 10,
   parameter int lives_width_p = 3,
   parameter int max_lives_p   = 5,
   parameter int start_lives_p = 2,
   parameter int ship_width_p  = 40,
   parameter int left_border_p = 9,
   parameter int right_border_p = 630,
   parameter int start_left_p  = 249,
   parameter int step_p        = 10,
   parameter int move_div_p    = 4,
   parameter int cooldown_p    = 8,
   parameter int flash_div_p   = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     move_left_i,
   input  logic                     move_right_i,
   input  logic                     shoot_i,
   input  logic                     hit_i,
   input  logic                     add_life_i,
   output logic                     alive_o,
   output logic                     shot_laser_o,
   output logic                     resume_o,
   output logic [pos_width_p-1:0]   pos_left_o,
   output logic [pos_width_p-1:0]   pos_right_o,
   output logic [pos_width_p-1:0]   gun_pos_o,
   output logic [lives_width_p-1:0] lives_o,
   output logic                     visible_o,
   output logic [2:0]               state_o
);

   localparam int PW = pos_width_p;
   localparam int LW = lives_width_p;
   localparam int MW = $clog2(move_div_p + 1);
   localparam int CW = $clog2(cooldown_p + 1);
   localparam int FW = $clog2(flash_div_p + 1);

   localparam logic [PW-1:0] LB      = PW'(left_border_p);
   localparam logic [PW-1:0] RB      = PW'(right_border_p);
   localparam logic [PW-1:0] RL      = PW'(right_border_p - ship_width_p);
   localparam logic [PW-1:0] STEP    = PW'(step_p);
   localparam logic [PW-1:0] START   = PW'(start_left_p);
   localparam logic [PW-1:0] SW      = PW'(ship_width_p);
   localparam logic [PW-1:0] SW_HALF = PW'(ship_width_p / 2);
   localparam logic [LW-1:0] LMAX    = LW'(max_lives_p);
   localparam logic [LW-1:0] LSTART  = LW'(start_lives_p);
   localparam logic [MW-1:0] MDIV_M1 = MW'(move_div_p - 1);
   localparam logic [CW-1:0] COOL    = CW'(cooldown_p);
   localparam logic [FW-1:0] FDIV_M1 = FW'(flash_div_p - 1);

   if (start_left_p < left_border_p || start_left_p > right_border_p - ship_width_p) begin : g_bad_start
      $error("player_ctrl: start_left_p outside the ship travel range");
   end
   if (start_lives_p > max_lives_p || max_lives_p >= (1 << lives_width_p)) begin : g_bad_lives
      $error("player_ctrl: lives parameters do not fit");
   end
   if (move_div_p < 1 || cooldown_p < 1 || flash_div_p < 1) begin : g_bad_div
      $error("player_ctrl: dividers must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEFT  = 3'd1,
      RIGHT = 3'd2,
      HIT   = 3'd3,
      DEAD  = 3'd4
   } state_t;

   state_t          state_q, state_n, move_dir;
   logic [PW-1:0]   pos_q, pos_n;
   logic [LW-1:0]   lives_q, lives_n;
   logic [MW-1:0]   mcnt_q, mcnt_n;
   logic [CW-1:0]   cool_q, cool_n;
   logic [FW-1:0]   fcnt_q, fcnt_n;
   logic            shot_q, shot_n;
   logic            resume_q, resume_n;
   logic            vis_q, vis_n;
   logic            shoot_q;
   logic            shoot_edge, dir_l, dir_r, at_l, at_r;
   logic [PW-1:0]   pos_right;

   assign pos_right  = pos_q + SW;
   assign shoot_edge = shoot_i & ~shoot_q;
   assign dir_l      = move_left_i & ~move_right_i;
   assign dir_r      = ~move_left_i & move_right_i;
   assign at_l       = pos_q <= LB;
   assign at_r       = pos_right >= RB;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         pos_q    <= START;
         lives_q  <= LSTART;
         mcnt_q   <= '0;
         cool_q   <= '0;
         fcnt_q   <= '0;
         shot_q   <= 1'b0;
         resume_q <= 1'b0;
         vis_q    <= 1'b1;
         shoot_q  <= 1'b0;
      end else begin
         state_q  <= state_n;
         pos_q    <= pos_n;
         lives_q  <= lives_n;
         mcnt_q   <= mcnt_n;
         cool_q   <= cool_n;
         fcnt_q   <= fcnt_n;
         shot_q   <= shot_n;
         resume_q <= resume_n;
         vis_q    <= vis_n;
         shoot_q  <= shoot_i;
      end
   end

   always_comb begin
      state_n  = state_q;
      pos_n    = pos_q;
      lives_n  = lives_q;
      mcnt_n   = mcnt_q;
      cool_n   = (cool_q != '0) ? cool_q - CW'(1) : '0;
      fcnt_n   = fcnt_q;
      shot_n   = 1'b0;
      resume_n = 1'b0;
      vis_n    = vis_q;
      move_dir = IDLE;

      case (state_q)
         IDLE, LEFT, RIGHT: begin
            vis_n  = 1'b1;
            fcnt_n = '0;
            if (hit_i) begin
               mcnt_n = '0;
               vis_n  = 1'b0;
               if (lives_q != '0) begin
                  lives_n = lives_q - LW'(1);
                  state_n = HIT;
               end else begin
                  state_n = DEAD;
               end
            end else begin
               if (dir_l && !at_l)      move_dir = LEFT;
               else if (dir_r && !at_r) move_dir = RIGHT;
               state_n = move_dir;
               // The step lands on the wrap edge, so entry never moves the ship.
               if (move_dir != state_q || state_q == IDLE) begin
                  mcnt_n = '0;
               end else if (mcnt_q == MDIV_M1) begin
                  mcnt_n = '0;
                  if (state_q == LEFT) pos_n = (pos_q - LB >= STEP) ? pos_q - STEP : LB;
                  else                 pos_n = (RL - pos_q >= STEP) ? pos_q + STEP : RL;
               end else begin
                  mcnt_n = mcnt_q + MW'(1);
               end
               if (shoot_edge && cool_q == '0) begin
                  shot_n = 1'b1;
                  cool_n = COOL;
               end
               if (add_life_i && lives_q < LMAX) lives_n = lives_q + LW'(1);
            end
         end
         HIT, DEAD: begin
            if (shoot_edge) begin
               resume_n = 1'b1;
               pos_n    = START;
               cool_n   = COOL;
               mcnt_n   = '0;
               fcnt_n   = '0;
               vis_n    = 1'b1;
               if (dir_l)      state_n = LEFT;
               else if (dir_r) state_n = RIGHT;
               else            state_n = IDLE;
               if (state_q == DEAD) lives_n = LSTART;
            end else if (state_q == HIT) begin
               if (fcnt_q == FDIV_M1) begin
                  fcnt_n = '0;
                  vis_n  = ~vis_q;
               end else begin
                  fcnt_n = fcnt_q + FW'(1);
               end
            end else begin
               vis_n = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            mcnt_n  = '0;
            vis_n   = 1'b1;
         end
      endcase
   end

   assign alive_o      = (state_q != DEAD);
   assign shot_laser_o = shot_q;
   assign resume_o     = resume_q;
   assign pos_left_o   = pos_q;
   assign pos_right_o  = pos_right;
   assign gun_pos_o    = pos_q + SW_HALF;
   assign lives_o      = lives_q;
   assign visible_o    = vis_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Randomised and directed bench for player_ctrl against a timestamp-based behavioural model.
module tb_player_ctrl;

   localparam int PW = 10, LW = 3, MAXL = 5, STARTL = 2, SW = 40, LB = 9, RB = 630;
   localparam int START = 249, STEP = 10, MD = 4, CD = 8, FD = 16;

   logic          clk_i = 1'b0;
   logic          reset_ni = 1'b0;
   logic          move_left_i = 1'b0, move_right_i = 1'b0, shoot_i = 1'b0, hit_i = 1'b0, add_life_i = 1'b0;
   logic          alive_o, shot_laser_o, resume_o, visible_o;
   logic [PW-1:0] pos_left_o, pos_right_o, gun_pos_o;
   logic [LW-1:0] lives_o;
   logic [2:0]    state_o;

   int tests = 0;
   int fails = 0;
   int shots = 0;

   player_ctrl #(
      .pos_width_p(PW), .lives_width_p(LW), .max_lives_p(MAXL), .start_lives_p(STARTL),
      .ship_width_p(SW), .left_border_p(LB), .right_border_p(RB), .start_left_p(START),
      .step_p(STEP), .move_div_p(MD), .cooldown_p(CD), .flash_div_p(FD)
   ) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .move_left_i(move_left_i), .move_right_i(move_right_i), .shoot_i(shoot_i),
      .hit_i(hit_i), .add_life_i(add_life_i),
      .alive_o(alive_o), .shot_laser_o(shot_laser_o), .resume_o(resume_o),
      .pos_left_o(pos_left_o), .pos_right_o(pos_right_o), .gun_pos_o(gun_pos_o),
      .lives_o(lives_o), .visible_o(visible_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   // Model keeps edge timestamps (entry into a move, last shot, hit entry) instead of counters.
   typedef struct {
      int state, pos, lives, shot, res, vis, shoot_q;
      int last, dentry, hentry, t;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.state = 0; r.pos = START; r.lives = STARTL; r.shot = 0; r.res = 0; r.vis = 1;
      r.shoot_q = 0; r.last = -1000; r.dentry = 0; r.hentry = 0; r.t = 0;
      return r;
   endfunction

   function automatic mdl_t mdl_next(mdl_t c, logic l, logic r, logic s, logic h, logic a);
      mdl_t n = c;
      int edge_s, dl, dr, nxt;
      edge_s = (s && !c.shoot_q) ? 1 : 0;
      dl = (l && !r) ? 1 : 0;
      dr = (!l && r) ? 1 : 0;
      n.shot = 0; n.res = 0; n.t = c.t + 1; n.shoot_q = s ? 1 : 0;
      if (c.state <= 2) begin
         if (h) begin
            n.vis = 0;
            if (c.lives > 0) begin n.lives = c.lives - 1; n.state = 3; n.hentry = c.t; end
            else n.state = 4;
         end else begin
            nxt = (dl == 1 && c.pos > LB) ? 1 : (dr == 1 && c.pos + SW < RB) ? 2 : 0;
            if (nxt != c.state) begin
               n.state = nxt; n.dentry = c.t;
            end else if (c.state != 0 && (c.t - c.dentry) % MD == 0) begin
               if (c.state == 1) n.pos = (c.pos - STEP < LB) ? LB : c.pos - STEP;
               else              n.pos = (c.pos + STEP > RB - SW) ? RB - SW : c.pos + STEP;
            end
            if (edge_s == 1 && c.t - c.last > CD) begin n.shot = 1; n.last = c.t; end
            if (a && c.lives < MAXL) n.lives = c.lives + 1;
            n.vis = 1;
         end
      end else if (edge_s == 1) begin
         n.res = 1; n.pos = START; n.last = c.t; n.dentry = c.t; n.vis = 1;
         n.state = (dl == 1) ? 1 : (dr == 1) ? 2 : 0;
         if (c.state == 4) n.lives = STARTL;
      end else if (c.state == 3) begin
         n.vis = ((c.t - c.hentry) / FD) % 2;
      end
      return n;
   endfunction

   always @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) m <= mdl_reset();
      else           m <= mdl_next(m, move_left_i, move_right_i, shoot_i, hit_i, add_life_i);
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock, then compare every output against the model.
   task automatic tick();
      @(negedge clk_i);
      if (shot_laser_o) shots++;
      chk("state", int'(state_o), m.state);
      chk("pos_left", int'(pos_left_o), m.pos);
      chk("pos_right", int'(pos_right_o), m.pos + SW);
      chk("gun_pos", int'(gun_pos_o), m.pos + SW / 2);
      chk("lives", int'(lives_o), m.lives);
      chk("shot", int'(shot_laser_o), m.shot);
      chk("resume", int'(resume_o), m.res);
      chk("visible", int'(visible_o), m.vis);
      chk("alive", int'(alive_o), (m.state == 4) ? 0 : 1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic shoot_press();
      shoot_i = 1'b1; tick();
      shoot_i = 1'b0; tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk_i);
      chk("rst_pos_left", int'(pos_left_o), 249);
      chk("rst_pos_right", int'(pos_right_o), 289);
      chk("rst_gun_pos", int'(gun_pos_o), 269);
      chk("rst_lives", int'(lives_o), 2);
      chk("rst_state", int'(state_o), 0);
      chk("rst_visible", int'(visible_o), 1);
      reset_ni = 1'b1;
      tick();

      // Walk left into the border.
      move_left_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (i == 0) chk("left_entry_state", int'(state_o), 1);
         if (i == 3) chk("left_no_step_yet", int'(pos_left_o), 249);
         if (i == 4) chk("left_first_step", int'(pos_left_o), 239);
      end
      chk("left_clamp_pos", int'(pos_left_o), 9);
      chk("left_clamp_right", int'(pos_right_o), 49);
      chk("left_clamp_state", int'(state_o), 0);
      move_left_i = 1'b0;
      tick();

      // Held button fires once; a press inside cooldown is dropped.
      shots = 0;
      shoot_i = 1'b1; ticks(20); shoot_i = 1'b0;
      chk("hold_shots", shots, 1);
      ticks(10);
      shots = 0;
      shoot_i = 1'b1; tick(); shoot_i = 1'b0;
      ticks(2);
      shoot_i = 1'b1; tick(); shoot_i = 1'b0;
      ticks(6);
      shoot_i = 1'b1; tick(); shoot_i = 1'b0;
      ticks(2);
      chk("cooldown_shots", shots, 2);

      // Hit with spare lives, blink, resume moving right.
      hit_i = 1'b1; tick(); hit_i = 1'b0;
      chk("hit_lives", int'(lives_o), 1);
      chk("hit_state", int'(state_o), 3);
      chk("hit_vis0", int'(visible_o), 0);
      hit_i = 1'b1; tick(); hit_i = 1'b0;
      chk("hit_ignored", int'(lives_o), 1);
      ticks(14);
      chk("blink_still_off", int'(visible_o), 0);
      tick();
      chk("blink_on", int'(visible_o), 1);
      move_right_i = 1'b1; shoot_i = 1'b1; tick();
      chk("resume_pulse", int'(resume_o), 1);
      chk("resume_pos", int'(pos_left_o), 249);
      chk("resume_state", int'(state_o), 2);
      chk("resume_no_shot", int'(shot_laser_o), 0);
      shoot_i = 1'b0; move_right_i = 1'b0; tick();

      // Last life gone, then new game.
      hit_i = 1'b1; tick(); hit_i = 1'b0;
      shoot_press();
      hit_i = 1'b1; tick(); hit_i = 1'b0;
      chk("dead_state", int'(state_o), 4);
      chk("dead_alive", int'(alive_o), 0);
      chk("dead_visible", int'(visible_o), 0);
      add_life_i = 1'b1; hit_i = 1'b1; ticks(3); add_life_i = 1'b0; hit_i = 1'b0;
      chk("dead_lives", int'(lives_o), 0);
      shoot_i = 1'b1; tick();
      chk("newgame_lives", int'(lives_o), 2);
      chk("newgame_state", int'(state_o), 0);
      chk("newgame_resume", int'(resume_o), 1);
      shoot_i = 1'b0; tick();

      // Lives saturate, and a hit beats a simultaneous award.
      for (int i = 0; i < 6; i++) begin
         add_life_i = 1'b1; tick(); add_life_i = 1'b0; tick();
      end
      chk("lives_sat", int'(lives_o), 5);
      for (int i = 0; i < 2; i++) begin
         hit_i = 1'b1; tick(); hit_i = 1'b0;
         shoot_press();
      end
      chk("lives_three", int'(lives_o), 3);
      add_life_i = 1'b1; hit_i = 1'b1; tick(); add_life_i = 1'b0; hit_i = 1'b0;
      chk("hit_beats_add_lives", int'(lives_o), 2);
      chk("hit_beats_add_state", int'(state_o), 3);
      shoot_press();

      // Asynchronous reset mid-move, away from any clock edge.
      add_life_i = 1'b1; tick(); add_life_i = 1'b0;
      move_left_i = 1'b1; ticks(7);
      @(posedge clk_i); #3;
      reset_ni = 1'b0;
      #1;
      chk("areset_pos", int'(pos_left_o), 249);
      chk("areset_gun", int'(gun_pos_o), 269);
      chk("areset_state", int'(state_o), 0);
      chk("areset_lives", int'(lives_o), 2);
      chk("areset_visible", int'(visible_o), 1);
      #2;
      reset_ni = 1'b1;
      move_left_i = 1'b0;
      tick();

      // Random play.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) begin
            move_left_i  = ($urandom_range(1) == 1);
            move_right_i = ($urandom_range(1) == 1);
         end
         if ($urandom_range(3) == 0) shoot_i = ~shoot_i;
         hit_i      = ($urandom_range(63) == 0);
         add_life_i = ($urandom_range(31) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
